tc_program_mem: RTL and testbench

//   Parametrised successor to the 8-bit program ROM: a program memory with a configurable

---
 rtl/tc_program_pkg.sv | 18 +
 rtl/tc_program_mem_if.sv | 40 ++++
 rtl/tc_program_loader.sv | 71 +++++++
 rtl/tc_program_mem.sv | 85 ++++++++
 tb/tb_tc_program_mem.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/tc_program_pkg.sv
// Shared types and helpers for the program memory and its loader.
// Holds the loader state enum, the pointer width helper and the read-port limit.
package tc_program_pkg;

    localparam int MAX_READ_PORTS = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    // Pointer width, never below one bit so DEPTH=1 still has a pointer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tc_program_mem_if.sv
// Bus between the program counter/host side and tc_program_mem.
// Carries the packed read ports and the streaming valid/ready loader.
interface tc_program_mem_if #(
    parameter int WORD_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int READ_PORTS = 1
);

    logic [READ_PORTS*ADDR_WIDTH-1:0] address;
    logic [READ_PORTS*WORD_WIDTH-1:0] out;
    logic                             out_valid;
    logic                             load_start;
    logic                             load_valid;
    logic [WORD_WIDTH-1:0]            load_data;
    logic                             load_ready;
    logic                             load_done;

    modport master (
        output address,
        output load_start,
        output load_valid,
        output load_data,
        input  out,
        input  out_valid,
        input  load_ready,
        input  load_done
    );

    modport slave (
        input  address,
        input  load_start,
        input  load_valid,
        input  load_data,
        output out,
        output out_valid,
        output load_ready,
        output load_done
    );

endinterface

// File: rtl/tc_program_loader.sv
// Loader FSM: IDLE -> LOAD -> DONE -> IDLE, sequential write pointer.
// Ports: clk, rst (async, active-low), load_start/load_valid in,
// load_ready/load_done out, we/waddr to the memory, state to the top.
module tc_program_loader
    import tc_program_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int PW    = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          load_valid,
    output logic          load_ready,
    output logic          load_done,
    output logic          we,
    output logic [PW-1:0] waddr,
    output state_t        state
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0] ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= '0;
            load_ready <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            load_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (load_start) begin
                        state      <= LOAD;
                        ptr        <= '0;
                        load_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    // A restart beats a coincident beat: that word is dropped.
                    if (load_start) begin
                        ptr <= '0;
                    end else if (load_valid) begin
                        if (ptr == LAST) begin
                            state      <= DONE;
                            ptr        <= '0;
                            load_ready <= 1'b0;
                            load_done  <= 1'b1;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    load_ready <= 1'b0;
                end
            endcase
        end
    end

    // load_ready is high exactly while in LOAD.
    assign we    = load_ready && load_valid && !load_start;
    assign waddr = ptr;

endmodule

// File: rtl/tc_program_mem.sv
// Program memory with runtime streaming loader and registered read ports.
// Ports: clk, rst (async, active-low), bus (tc_program_mem_if.slave).
module tc_program_mem
    import tc_program_pkg::*;
#(
    parameter int WORD_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int READ_PORTS = 1
) (
    input  logic               clk,
    input  logic               rst,
    tc_program_mem_if.slave    bus
);

    localparam int          PW      = ptr_width(DEPTH);
    localparam logic [32:0] DEPTH_L = 33'(DEPTH);

    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [WORD_WIDTH-1:0] rdata [READ_PORTS];
    logic                  we;
    logic [PW-1:0]         waddr;
    state_t                state;
    logic                  rd_en;

    tc_program_loader #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_loader (
        .clk        (clk),
        .rst        (rst),
        .load_start (bus.load_start),
        .load_valid (bus.load_valid),
        .load_ready (bus.load_ready),
        .load_done  (bus.load_done),
        .we         (we),
        .waddr      (waddr),
        .state      (state)
    );

    // Contents survive reset so a program is kept across core resets.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= bus.load_data;
        end
    end

    // Reads are live only when the next cycle is IDLE.
    assign rd_en = ((state == IDLE) && !bus.load_start) ||
                   (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= rd_en;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic                  in_range;

        assign addr     = bus.address[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign in_range = 33'(addr) < DEPTH_L;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rdata[p] <= '0;
            end else if (rd_en && in_range) begin
                rdata[p] <= mem[addr[PW-1:0]];
            end else begin
                rdata[p] <= '0;
            end
        end
    end

    always_comb begin
        bus.out = '0;
        for (int p = 0; p < READ_PORTS; p++) begin
            bus.out[p*WORD_WIDTH +: WORD_WIDTH] = rdata[p];
        end
    end

endmodule

// File: tb/tb_tc_program_mem.sv
// Directed bench for tc_program_mem: DEPTH=8, 8-bit words, 3 read ports.
// Covers reset, full load, backpressure, restart, multi-port and mid-load reset.
module tb_tc_program_mem;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    tc_program_mem_if #(
        .WORD_WIDTH (8),
        .ADDR_WIDTH (16),
        .READ_PORTS (3)
    ) bus ();

    tc_program_mem #(
        .WORD_WIDTH (8),
        .ADDR_WIDTH (16),
        .DEPTH      (8),
        .READ_PORTS (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always @(posedge clk) begin
        if (bus.load_done === 1'b1) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input logic [15:0] a2, input logic [15:0] a1,
                            input logic [15:0] a0);
        bus.address = {a2, a1, a0};
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] e);
        set_addr(a, a, a);
        step();
        chk($sformatf("rd[%0d]", a), {8'h0, bus.out}, {8'h0, e, e, e});
        chk("rd_valid", {31'b0, bus.out_valid}, 32'd1);
    endtask

    task automatic stream(input logic [7:0] base, input bit gaps);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) begin
            if (gaps && i > 0) begin
                bus.load_valid = 1'b0;
                bus.load_data  = 8'hFF;
                step();
            end
            bus.load_valid = 1'b1;
            bus.load_data  = base + 8'(i);
            if (i == 7)
                chk("no_early_done", {31'b0, bus.load_done}, 32'd0);
            step();
        end
        bus.load_valid = 1'b0;
        chk("done_pulse", {31'b0, bus.load_done}, 32'd1);
        chk("done_ready", {31'b0, bus.load_ready}, 32'd0);
        chk("done_out0", {8'h0, bus.out}, 32'd0);
        step();
        chk("done_drop", {31'b0, bus.load_done}, 32'd0);
        chk("idle_valid", {31'b0, bus.out_valid}, 32'd1);
        chk("done_once", done_cnt - d0, 32'd1);
    endtask

    task automatic start();
        bus.load_start = 1'b1;
        step();
        bus.load_start = 1'b0;
        chk("ld_ready", {31'b0, bus.load_ready}, 32'd1);
        chk("ld_ovalid", {31'b0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        int d0;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
        set_addr(16'd5, 16'd5, 16'd5);

        // Reset held for 10 cycles
        repeat (10) @(posedge clk);
        #1;
        chk("rst_out", {8'h0, bus.out}, 32'd0);
        chk("rst_ovalid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_ready", {31'b0, bus.load_ready}, 32'd0);
        chk("rst_done", {31'b0, bus.load_done}, 32'd0);
        rst = 1'b1;
        step();
        chk("rel_ovalid", {31'b0, bus.out_valid}, 32'd1);

        // Full gap-free load 10..17
        start();
        stream(8'h10, 1'b0);
        for (int a = 0; a < 8; a++) rd(16'(a), 8'h10 + 8'(a));

        // Latency: a new address shows only after the next edge
        rd(16'd2, 8'h12);
        set_addr(16'd3, 16'd3, 16'd3);
        #2;
        chk("lat_hold", {8'h0, bus.out}, 32'h00121212);
        step();
        chk("lat_new", {8'h0, bus.out}, 32'h00131313);

        // Backpressure load A0..A7
        start();
        stream(8'hA0, 1'b1);
        for (int a = 0; a < 8; a++) rd(16'(a), 8'hA0 + 8'(a));

        // Restart after 3 words; restart coincides with a beat
        d0 = done_cnt;
        start();
        for (int i = 0; i < 3; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 8'hD0 + 8'(i);
            step();
        end
        bus.load_start = 1'b1;
        bus.load_data  = 8'h99;
        step();
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        chk("rs_ready", {31'b0, bus.load_ready}, 32'd1);
        chk("rs_ovalid", {31'b0, bus.out_valid}, 32'd0);
        stream(8'hC0, 1'b0);
        chk("rs_done_once", done_cnt - d0, 32'd1);
        for (int a = 0; a < 8; a++) rd(16'(a), 8'hC0 + 8'(a));

        // Multi-port, shared and out-of-range addresses
        set_addr(16'd300, 16'd2, 16'd2);
        step();
        chk("mp_a", {8'h0, bus.out}, 32'h0000C2C2);
        set_addr(16'd8, 16'd7, 16'd0);
        step();
        chk("mp_b", {8'h0, bus.out}, 32'h0000C7C0);
        set_addr(16'hFFFF, 16'd5, 16'd1);
        step();
        chk("mp_c", {8'h0, bus.out}, 32'h0000C5C1);

        // Reset after 4 words of a new load
        start();
        for (int i = 0; i < 4; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 8'h50 + 8'(i);
            step();
        end
        bus.load_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("mr_ready", {31'b0, bus.load_ready}, 32'd0);
        chk("mr_ovalid", {31'b0, bus.out_valid}, 32'd0);
        chk("mr_done", {31'b0, bus.load_done}, 32'd0);
        step();
        step();
        rst = 1'b1;
        step();
        chk("mr_rel", {31'b0, bus.out_valid}, 32'd1);
        for (int a = 0; a < 4; a++) rd(16'(a), 8'h50 + 8'(a));
        for (int a = 4; a < 8; a++) rd(16'(a), 8'hC0 + 8'(a));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
